shared_dff_arbiter: RTL and testbench

Arbitrates write access from N requesters to a single shared W-bit D-flip-flop register bank.
- Picks one pending requester, issues a one-cycle grant and captures that requester's data into the register.
- Reports which requester last wrote the register.
- Sits between several producer blocks and one shared storage register in the sequential fundamentals library; it is the controller that shares the DFF resource.

---
 rtl/shared_dff_arbiter.sv | 94 +++++++++
 tb/tb_shared_dff_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shared_dff_arbiter.sv
// rtl/shared_dff_arbiter.sv - arbitrates N requesters onto one shared W-bit register
// Define SHARED_DFF_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module shared_dff_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] q_owner,
    output logic                 q_valid
);

    localparam int IW = $clog2(N);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] win;
    logic [IW-1:0] pick;

`ifdef SHARED_DFF_ARB_RR_EN
    localparam logic [IW:0] NV = (IW+1)'(N);
    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan offsets from far to near so the first requester at or after ptr wins.
    always_comb begin
        pick = '0;
        sum  = '0;
        idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                pick = idx;
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            win     <= '0;
            q       <= '0;
            q_owner <= '0;
            q_valid <= 1'b0;
`ifdef SHARED_DFF_ARB_RR_EN
            ptr     <= '0;
`endif
        end else if (state == IDLE) begin
            if (|req) begin
                win   <= pick;
                gnt   <= {{(N-1){1'b0}}, 1'b1} << pick;
                state <= GRANT;
            end
        end else begin
            // A requester that withdrew during its grant cycle cancels the write.
            if (req[win]) begin
                q       <= wdata[int'(win)*W +: W];
                q_owner <= win;
                q_valid <= 1'b1;
            end
            gnt   <= '0;
            state <= IDLE;
`ifdef SHARED_DFF_ARB_RR_EN
            if (win == IW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= win + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shared_dff_arbiter.sv
// tb/tb_shared_dff_arbiter.sv - directed self-checking bench for shared_dff_arbiter
module tb_shared_dff_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  q_owner;
    logic        q_valid;

    int checks = 0;
    int errors = 0;

`ifdef SHARED_DFF_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    shared_dff_arbiter #(.N(4), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        rst   = 1'b1;
        req   = 4'b0000;
        wdata = 32'h0;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_owner", 32'(q_owner), 32'h0);
        chk("reset_valid", 32'(q_valid), 32'h0);
        rst = 1'b0;

        // single request from requester 2
        req = 4'b0100;
        wdata[23:16] = 8'hA5;
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_valid_pre", 32'(q_valid), 32'h0);
        step();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_owner", 32'(q_owner), 32'h2);
        chk("single_valid", 32'(q_valid), 32'h1);
        chk("single_gnt_off", 32'(gnt), 32'h0);
        req = 4'b0000;

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        chk("async_q", 32'(q), 32'h0);
        chk("async_owner", 32'(q_owner), 32'h0);
        chk("async_valid", 32'(q_valid), 32'h0);
        chk("async_gnt", 32'(gnt), 32'h0);
        step();
        rst = 1'b0;

        // all requesters held
        for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = RR ? (k % 4) : 0;
            step();
            chk("all_gnt", 32'(gnt), 32'(1) << e);
            step();
            chk("all_gnt_off", 32'(gnt), 32'h0);
            chk("all_owner", 32'(q_owner), 32'(e));
            chk("all_q", 32'(q), 32'h10 + 32'(e));
        end
        req = 4'b0000;

        // cancelled write
        req = 4'b0001;
        wdata[7:0] = 8'h3C;
        step();
        chk("pre_gnt", 32'(gnt), 32'h1);
        step();
        chk("pre_q", 32'(q), 32'h3C);
        req = 4'b0010;
        wdata[15:8] = 8'h99;
        step();
        chk("cancel_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        chk("cancel_q", 32'(q), 32'h3C);
        chk("cancel_owner", 32'(q_owner), 32'h0);
        chk("cancel_valid", 32'(q_valid), 32'h1);
        chk("cancel_gnt_off", 32'(gnt), 32'h0);

        // pointer moved past the cancelled requester
        req = 4'b0110;
        step();
        chk("ptr_gnt", 32'(gnt), RR ? 32'h4 : 32'h2);
        step();
        chk("ptr_owner", 32'(q_owner), RR ? 32'h2 : 32'h1);
        chk("ptr_q", 32'(q), RR ? 32'h12 : 32'h99);
        req = 4'b0000;

        // winner held during grant
        req = 4'b1000;
        wdata[31:24] = 8'hC3;
        step();
        chk("stab_gnt", 32'(gnt), 32'h8);
        req = 4'b1001;
        wdata[7:0] = 8'h5A;
        #1;
        chk("stab_gnt_hold", 32'(gnt), 32'h8);
        step();
        chk("stab_gnt_off", 32'(gnt), 32'h0);
        chk("stab_q", 32'(q), 32'hC3);
        chk("stab_owner", 32'(q_owner), 32'h3);
        req = 4'b0001;
        step();
        chk("stab_next_gnt", 32'(gnt), 32'h1);
        step();
        chk("stab_next_q", 32'(q), 32'h5A);
        chk("stab_next_owner", 32'(q_owner), 32'h0);
        req = 4'b0000;

        // reset during a grant cycle
        req = 4'b0010;
        wdata[15:8] = 8'h77;
        step();
        chk("midrst_gnt", 32'(gnt), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("midrst_gnt_off", 32'(gnt), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_valid", 32'(q_valid), 32'h0);
        chk("midrst_owner", 32'(q_owner), 32'h0);
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_gnt", 32'(gnt), 32'h0);
        chk("post_q", 32'(q), 32'h0);
        chk("post_valid", 32'(q_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
